pu_riscv_bp: RTL
================

Name: pu_riscv_bp

Overview:
- Branch prediction table at the other end of the branch unit's predictor-update interface.
- Consumes resolved-branch updates (bu_bp_update, bu_bp_btaken, bu_bp_predict, bu_bp_history) from the execute stage and trains a gshare-indexed table of 2-bit saturating counters.
- Returns a registered 2-bit prediction for the fetch PC; the decode stage forwards it to execute as id_bp_predict.
- An internal init state machine clears the table after reset.

Parameters:
- XLEN, 64, program counter width.
- HAS_BPU, 1, 0 = predictor disabled: prediction constant 2'b00, no table.
- HAS_RVC, 1, nonzero = PC index taken from bit 1 upward, else from bit 2 upward.
- BP_GLOBAL_BITS, 2, global history bits in the index; must match the branch unit.
- BP_LOCAL_BITS, 10, PC bits in the index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_stall  input  1  holds the prediction register.
- if_parcel_pc  input  XLEN  PC of the fetch parcel being predicted.
- bp_bp_predict  output  2  registered prediction counter; bit 1 = predict taken.
- bp_init_busy  output  1  table initialisation in progress.
- ex_pc  input  XLEN  PC of the branch resolved in execute.
- bu_bp_history  input  BP_GLOBAL_BITS  global history supplied by the branch unit.
- bu_bp_predict  input  2  counter value originally predicted for the resolved branch.
- bu_bp_btaken  input  1  resolved outcome, 1 = taken.
- bu_bp_update  input  1  qualifies one update this cycle.

Behaviour:
- Geometry: DEPTH = 2^(BP_GLOBAL_BITS+BP_LOCAL_BITS) entries x 2 bits. Default is 4096 entries.
- Index function: idx(pc) = {bu_bp_history, pc[OFS+BP_LOCAL_BITS-1:OFS]}, with OFS = 1 if HAS_RVC else 2.
  - Lookup uses if_parcel_pc.
  - Update uses ex_pc.
  - Both use the current bu_bp_history.
- Reset (rst=1, async): FSM state = INIT, init_cnt = 0, bp_bp_predict = 2'b00, bp_init_busy = 1. Table contents are undefined until INIT completes.
- FSM state INIT:
  - Each cycle write 2'b01 (weakly not-taken) to entry init_cnt, then init_cnt++.
  - When init_cnt == DEPTH-1 is written, go to RUN at the next edge. INIT lasts exactly DEPTH cycles after reset deassertion.
  - bu_bp_update is ignored.
  - bp_bp_predict is forced to 2'b00.
  - bp_init_busy = 1.
- FSM state RUN: bp_init_busy = 0. The FSM never leaves RUN except through rst. Asserting rst mid-INIT or mid-RUN restarts INIT from entry 0.
- Update rule (RUN, bu_bp_update=1): write to entry idx(ex_pc) the value
  - btaken=1: sat_inc(bu_bp_predict), saturating at 2'b11.
  - btaken=0: sat_dec(bu_bp_predict), saturating at 2'b00.
  - The new value is computed from bu_bp_predict, not from a table re-read.
  - At most one write per cycle.
- Lookup (RUN):
  - If id_stall=0, bp_bp_predict <= table[idx(if_parcel_pc)] at the next edge. Latency is 1 cycle.
  - If id_stall=1, bp_bp_predict holds its value.
  - Updates still commit while stalled.
- Read/write collision: if the lookup index equals the update index in the same cycle, bp_bp_predict receives the newly written value (write-through bypass).
- Width rules: indices are BP_GLOBAL_BITS+BP_LOCAL_BITS bits. init_cnt wraps naturally and is unused after INIT. No X may reach bp_bp_predict in RUN.
- HAS_BPU=0:
  - No table and no FSM.
  - bp_bp_predict = 2'b00 always.
  - bp_init_busy = 0 once rst is deasserted (1 during rst).
  - Update inputs are ignored.

Test Plan:
- Reset release, defaults -> bp_init_busy=1 for exactly 4096 cycles; bp_bp_predict=2'b00 throughout. After INIT, lookup of any PC returns 2'b01.
- After INIT, history=2'b00: update ex_pc=0x8000_0010, predict=2'b01, btaken=1 -> next cycle, lookup if_parcel_pc=0x8000_0010 returns 2'b10.
- Saturation: update predict=2'b11 btaken=1 -> entry 2'b11. Update predict=2'b00 btaken=0 -> entry 2'b00.
- Collision: same cycle, update idx(0x8000_0020) with predict=2'b01/btaken=1 and lookup 0x8000_0020 -> bp_bp_predict=2'b10 the next cycle (bypass).
- History aliasing: update 0x8000_0040 with history=2'b01 to 2'b11; lookup same PC with history=2'b10 -> 2'b01, with history=2'b01 -> 2'b11.
- Stall and reset:
  - id_stall=1 with changing if_parcel_pc -> bp_bp_predict unchanged while stalled; an update issued during the stall is visible after the stall releases.
  - rst pulsed mid-INIT (at cycle 100) -> init restarts, bp_init_busy high for another full 4096 cycles.

Source files
------------

// File: rtl/pu_riscv_bp.sv
// pu_riscv_bp: gshare branch predictor table of 2-bit saturating counters.
// The table is trained from resolved branches and cleared to weakly-not-taken after reset.
module pu_riscv_bp #(
    parameter int XLEN           = 64,
    parameter int HAS_BPU        = 1,
    parameter int HAS_RVC        = 1,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_stall,
    input  logic [XLEN-1:0]           if_parcel_pc,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_init_busy,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    input  logic [1:0]                bu_bp_predict,
    input  logic                      bu_bp_btaken,
    input  logic                      bu_bp_update
);
    localparam int IW    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 1 << IW;
    localparam int OFS   = HAS_RVC != 0 ? 1 : 2;

    generate
        if (HAS_BPU != 0) begin : g_bpu
            typedef enum logic {INIT, RUN} state_t;
            state_t        state, state_nxt;
            logic [IW-1:0] init_cnt, ridx, widx, waddr;
            logic [1:0]    tbl [DEPTH];
            logic [1:0]    upd, wdata;
            logic          we;
            logic          unused;

            assign unused = ^{if_parcel_pc, ex_pc};
            assign ridx   = {bu_bp_history, if_parcel_pc[OFS +: BP_LOCAL_BITS]};
            assign widx   = {bu_bp_history, ex_pc[OFS +: BP_LOCAL_BITS]};
            // New counter comes from the value originally predicted, not a re-read.
            assign upd = bu_bp_btaken ? (bu_bp_predict == 2'b11 ? 2'b11 : bu_bp_predict + 2'b01)
                                      : (bu_bp_predict == 2'b00 ? 2'b00 : bu_bp_predict - 2'b01);

            always_comb begin
                state_nxt = (state == INIT && init_cnt == {IW{1'b1}}) ? RUN : state;
                we        = state == INIT || bu_bp_update;
                waddr     = state == INIT ? init_cnt : widx;
                wdata     = state == INIT ? 2'b01 : upd;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state         <= INIT;
                    init_cnt      <= '0;
                    bp_bp_predict <= 2'b00;
                end else begin
                    state <= state_nxt;
                    if (state == INIT) init_cnt <= init_cnt + 1'b1;
                    // Write-through bypass when lookup and update hit the same entry.
                    if (state == INIT) bp_bp_predict <= 2'b00;
                    else if (!id_stall) bp_bp_predict <= (we && waddr == ridx) ? wdata : tbl[ridx];
                end
            end

            always_ff @(posedge clk) begin
                if (we) tbl[waddr] <= wdata;
            end

            assign bp_init_busy = state == INIT;
        end else begin : g_nobpu
            logic unused;
            assign unused        = ^{clk, id_stall, if_parcel_pc, ex_pc, bu_bp_history,
                                     bu_bp_predict, bu_bp_btaken, bu_bp_update};
            assign bp_bp_predict = 2'b00;
            assign bp_init_busy  = rst;
        end
    endgenerate
endmodule
